ex_div_ctrl: RTL
================

Name: ex_div_ctrl

Overview:
- Multi-cycle sequencer for the RV64M divide/remainder instructions in the EX stage: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the single-cycle EX ALU and takes the same id_ex operands.
- Runs a 64-iteration restoring divider under an FSM and asserts hold_flag_o to ctrl until the result is ready.
- Writes the result back through its own rd write port. The writeback mux selects this port whenever reg_wen_o is 1.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- ITER, 64, number of restoring iterations. Must equal XLEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- inst_i  in  32  instruction from id_ex.
- op1_i  in  64  rs1 value (dividend).
- op2_i  in  64  rs2 value (divisor).
- rd_addr_i  in  5  destination register.
- kill_i  in  1  synchronous abort from ctrl (older jump/flush).
- rd_wdata_o  out  64  result.
- rd_waddr_o  out  5  destination register.
- reg_wen_o  out  1  one-cycle write strobe.
- hold_flag_o  out  1  stall request to ctrl.
- busy_o  out  1  state != IDLE.

Behaviour:
- Decode:
  - is_div = opcode 0110011 or 0111011, and func7 = 0000001, and func3[2] = 1.
  - func3[1] = 1 selects remainder; func3[0] = 1 selects unsigned.
  - Opcode 0111011 is a W op.
- W operand extension: for W ops the low 32 bits of each operand are sign-extended (signed ops) or zero-extended (unsigned ops) to 64 bits before dividing.
- States: IDLE, CALC, DONE.
- IDLE, is_div and kill_i = 0, at the clock edge (E0):
  - Latch rd, op type, |dividend| and |divisor| (absolute values only for signed ops), plus the sign flags.
  - Clear the remainder register and the counter.
  - Divisor = 0: go to DONE with quot = all ones, rem = original dividend.
  - Signed overflow (dividend = most-negative value and divisor = -1, judged at 32 bits for W ops): go to DONE with quot = dividend, rem = 0.
  - Otherwise go to CALC.
- CALC, one restoring step per edge:
  - Shift {rem, quot} left by 1.
  - If rem >= divisor: rem -= divisor and set quot LSB.
  - Counter increments. On the edge that performs iteration ITER-1, go to DONE.
  - The iterations occupy edges E1..E64.
- DONE, for one cycle:
  - Sign fix (normal path only): quotient is negated if the dividend and divisor signs differ (signed ops). Remainder takes the sign of the dividend.
  - W ops: the selected result's bit 31 is sign-extended into [63:32].
  - Outputs: reg_wen_o = 1, rd_waddr_o = latched rd, rd_wdata_o = quot or rem.
  - Next edge returns to IDLE.
- Latency:
  - Normal path: reg_wen_o is high in the cycle after E64, i.e. 65 cycles after start.
  - Special cases: reg_wen_o is high in the cycle after E0.
- hold_flag_o (combinational) = (IDLE & is_div & ~kill_i) | CALC.
  - It is low in DONE so the pipeline advances as the result retires.
  - A new is_div in the DONE cycle is ignored; it is accepted in IDLE on the following cycle.
- When not in DONE: reg_wen_o = 0, rd_wdata_o = 0, rd_waddr_o = 0.
- kill_i = 1 in any state: go to IDLE next edge, no reg_wen_o pulse. kill_i takes priority over a DONE completion, which is suppressed.
- Reset (rst = 0, asynchronous, any time):
  - state = IDLE; all registers cleared.
  - All outputs 0 immediately.
  - After release, a new start is accepted on the first edge.
- Instructions other than is_div: the block stays in IDLE and keeps all outputs 0.
- Operand changes while busy are ignored; the latched copies are used.

Test Plan:
- DIV 100 / -7, rd = 5:
  - hold_flag_o is high for 65 cycles starting from the start cycle.
  - In the following cycle: reg_wen_o = 1, rd_waddr_o = 5, rd_wdata_o = 0xFFFFFFFFFFFFFFF2 (-14).
  - REM with the same operands gives 2.
- REMU 0xFFFFFFFFFFFFFFFF / 10 -> rd_wdata_o = 5. DIVU with the same operands -> 0x1999999999999999.
- Divide by zero, each with reg_wen_o in the cycle after start and hold_flag_o high only in the start cycle:
  - DIVU 5 / 0 -> 0xFFFFFFFFFFFFFFFF.
  - REM 5 / 0 -> 5.
- Signed overflow:
  - DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
  - REM with the same operands -> 0.
  - DIVW op1 = 0x0000000080000000, op2 = 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000.
- W ops with garbage in the upper operand bits:
  - REMW op1 = 0x12345678FFFFFFF9 (-7), op2 = 2 -> 0xFFFFFFFFFFFFFFFF (-1).
  - DIVUW same op1, op2 = 2 -> 0x000000007FFFFFFC.
- Abort and reset:
  - kill_i at cycle 30 of CALC -> next cycle busy_o = 0, and no reg_wen_o pulse ever.
  - A DIV 9 / 3 issued immediately afterwards returns 3.
  - Separately, rst low at cycle 40 -> all outputs 0 at once; a DIV 9 / 3 after release returns 3.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle sequencer for RV64M DIV/DIVU/REM/REMU and their
// W forms. It sits beside the EX ALU, runs a restoring divider for ITER
// steps and stalls the pipeline through hold_flag_o. The result is written
// back through a private rd write port with a one-cycle strobe.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   inst_i          instruction from id_ex
//   op1_i, op2_i    dividend / divisor
//   rd_addr_i       destination register
//   kill_i          synchronous abort (older flush)
//   rd_wdata_o      result data, valid while reg_wen_o
//   rd_waddr_o      result register, valid while reg_wen_o
//   reg_wen_o       one-cycle write strobe
//   hold_flag_o     stall request to ctrl
//   busy_o          sequencer not idle
module ex_div_ctrl #(
  parameter int XLEN = 64,
  parameter int ITER = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic [4:0]      rd_waddr_o,
  output logic            reg_wen_o,
  output logic            hold_flag_o,
  output logic            busy_o
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            sel_rem_q, sel_rem_d;
  logic            w_q, w_d;
  logic            neg_q_q, neg_q_d;   // negate quotient on completion
  logic            neg_r_q, neg_r_d;   // negate remainder on completion
  logic            spec_q, spec_d;     // result already final (div-by-0 / overflow)

  // Decode
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       is_w, is_div, is_rem, is_uns;

  assign opcode = inst_i[6:0];
  assign func3  = inst_i[14:12];
  assign func7  = inst_i[31:25];
  assign is_w   = (opcode == 7'b0111011);
  assign is_div = ((opcode == 7'b0110011) || is_w) && (func7 == 7'b0000001) && func3[2];
  assign is_rem = func3[1];
  assign is_uns = func3[0];

  logic unused_inst;
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  // Operand extension and magnitude
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic            a_neg, b_neg, b_zero, ovf;

  always_comb begin
    a_ext = op1_i;
    b_ext = op2_i;
    if (is_w) begin
      a_ext = is_uns ? {32'b0, op1_i[31:0]} : {{(XLEN-32){op1_i[31]}}, op1_i[31:0]};
      b_ext = is_uns ? {32'b0, op2_i[31:0]} : {{(XLEN-32){op2_i[31]}}, op2_i[31:0]};
    end
  end

  assign a_neg  = ~is_uns & a_ext[XLEN-1];
  assign b_neg  = ~is_uns & b_ext[XLEN-1];
  assign a_abs  = a_neg ? -a_ext : a_ext;
  assign b_abs  = b_neg ? -b_ext : b_ext;
  assign b_zero = (b_ext == '0);
  // Most-negative / -1; for W ops the extended values make this a 32-bit test
  assign ovf    = ~is_uns && (a_ext == {1'b1, {(XLEN-1){1'b0}}} ||
                              (is_w && a_ext[31:0] == 32'h8000_0000 && a_ext[XLEN-1]))
                          && (b_ext == '1);

  // One restoring step; 65-bit partial remainder since an unsigned divisor
  // may exceed 2^63.
  logic [XLEN:0]   r_sh, r_sub;
  logic            r_ge;

  assign r_sh  = {rem_q, quot_q[XLEN-1]};
  assign r_sub = r_sh - {1'b0, dvsr_q};
  assign r_ge  = (r_sh >= {1'b0, dvsr_q});

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    sel_rem_d = sel_rem_q;
    w_d       = w_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    spec_d    = spec_q;
    case (state_q)
      IDLE: begin
        if (is_div && !kill_i) begin
          rd_d      = rd_addr_i;
          sel_rem_d = is_rem;
          w_d       = is_w;
          neg_q_d   = a_neg ^ b_neg;
          neg_r_d   = a_neg;
          dvsr_d    = b_abs;
          cnt_d     = '0;
          if (b_zero) begin
            spec_d  = 1'b1;
            quot_d  = '1;
            rem_d   = a_ext;
            state_d = DONE;
          end else if (ovf) begin
            spec_d  = 1'b1;
            quot_d  = a_ext;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            spec_d  = 1'b0;
            quot_d  = a_abs;
            rem_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = r_ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], r_ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      sel_rem_q <= 1'b0;
      w_q       <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      spec_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      sel_rem_q <= sel_rem_d;
      w_q       <= w_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      spec_q    <= spec_d;
    end
  end

  // Result assembly
  logic [XLEN-1:0] q_fix, r_fix, res_sel, res;
  logic            wen;

  assign q_fix   = (!spec_q && neg_q_q) ? -quot_q : quot_q;
  assign r_fix   = (!spec_q && neg_r_q) ? -rem_q  : rem_q;
  assign res_sel = sel_rem_q ? r_fix : q_fix;
  assign res     = w_q ? {{(XLEN-32){res_sel[31]}}, res_sel[31:0]} : res_sel;

  // A kill in the DONE cycle suppresses the write.
  assign wen         = (state_q == DONE) && !kill_i;
  assign reg_wen_o   = wen;
  assign rd_wdata_o  = wen ? res  : '0;
  assign rd_waddr_o  = wen ? rd_q : '0;
  // Gated by rst so every output is 0 while reset is held.
  assign hold_flag_o = rst && (((state_q == IDLE) && is_div && !kill_i) || (state_q == CALC));
  assign busy_o      = (state_q != IDLE);

endmodule
